ahb_lite_cmd_master: RTL and testbench

- AHB-Lite initiator (bus master) that turns a simple valid/ready command stream into pipelined single NONSEQ transfers.
- Drives the same io_ahb_0_* port bundle that the testbench RAM slave port receives.
- Used in the testbench to preload, peek and poke memory independently of the core.
- Returns one response per command, in order.

---
 rtl/ahb_lite_cmd_master.sv | 145 ++++++++++++++
 tb/tb_ahb_lite_cmd_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: valid/ready command stream to pipelined NONSEQ transfers.
// Optional stall timeout: define AHB_LITE_CMD_MASTER_TIMEOUT_EN.
module ahb_lite_cmd_master #(
  parameter int ADDR_W         = 31,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              hung,
  output logic [1:0]        io_ahb_0_htrans,
  output logic [2:0]        io_ahb_0_hsize,
  output logic              io_ahb_0_hwrite,
  output logic [ADDR_W-1:0] io_ahb_0_haddr,
  output logic [DATA_W-1:0] io_ahb_0_hwdata,
  input  logic              io_ahb_0_hready,
  input  logic              io_ahb_0_hresp,
  input  logic [DATA_W-1:0] io_ahb_0_hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic              ap_valid;
  logic              ap_write;
  logic [2:0]        ap_size;
  logic [ADDR_W-1:0] ap_addr;
  logic [DATA_W-1:0] ap_wdata;

  logic              dp_valid;
  logic              dp_write;
  logic [DATA_W-1:0] dp_wdata;

  logic accept;
  logic ap_done;
  logic dp_done;
  logic tmo_hit;
  logic tmo_pend;

  assign cmd_ready = !hung && (!ap_valid || io_ahb_0_hready);
  assign accept    = cmd_valid && cmd_ready;
  assign ap_done   = ap_valid && io_ahb_0_hready;
  assign dp_done   = dp_valid && io_ahb_0_hready;

  assign io_ahb_0_htrans = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign io_ahb_0_hsize  = ap_size;
  assign io_ahb_0_hwrite = ap_write;
  assign io_ahb_0_haddr  = ap_addr;
  assign io_ahb_0_hwdata = dp_wdata;

`ifdef AHB_LITE_CMD_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;
  logic          hung_q;

  assign tmo_hit = dp_valid && !io_ahb_0_hready
                && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign hung    = hung_q;

  // A command taken in the timeout cycle itself still owes a response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt  <= '0;
      tmo_pend <= 1'b0;
      hung_q   <= 1'b0;
    end else begin
      tmo_pend <= tmo_hit && (ap_valid || accept);
      if (tmo_hit)
        hung_q <= 1'b1;
      if (io_ahb_0_hready)
        tmo_cnt <= '0;
      else if (dp_valid)
        tmo_cnt <= tmo_cnt + CW'(1);
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign tmo_pend = 1'b0;
  assign hung     = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ap_valid  <= 1'b0;
      ap_write  <= 1'b0;
      ap_size   <= '0;
      ap_addr   <= '0;
      ap_wdata  <= '0;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= dp_done;
      rsp_err   <= dp_done && io_ahb_0_hresp;
      rsp_rdata <= (dp_done && !dp_write) ? io_ahb_0_hrdata : '0;

      if (accept) begin
        ap_valid <= 1'b1;
        ap_write <= cmd_write;
        ap_size  <= cmd_size;
        ap_addr  <= cmd_addr;
        ap_wdata <= cmd_wdata;
      end else if (ap_done) begin
        ap_valid <= 1'b0;
      end

      if (ap_done) begin
        dp_valid <= 1'b1;
        dp_write <= ap_write;
        dp_wdata <= ap_wdata;
      end else if (dp_done) begin
        dp_valid <= 1'b0;
      end

      if (tmo_hit) begin
        ap_valid <= 1'b0;
        dp_valid <= 1'b0;
      end

      if (tmo_hit || tmo_pend) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: AHB slave model plus in-order
// command/response reference model with randomized traffic.
module tb_ahb_lite_cmd_master;

  localparam int AW = 31;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [2:0]    cmd_size = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          hung;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          hready = 1'b1;
  logic          hresp = 1'b0;
  logic [DW-1:0] hrdata = '0;

  always #5 clock = ~clock;

  ahb_lite_cmd_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_size(cmd_size),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .hung(hung),
    .io_ahb_0_htrans(htrans), .io_ahb_0_hsize(hsize),
    .io_ahb_0_hwrite(hwrite), .io_ahb_0_haddr(haddr),
    .io_ahb_0_hwdata(hwdata), .io_ahb_0_hready(hready),
    .io_ahb_0_hresp(hresp), .io_ahb_0_hrdata(hrdata)
  );

  typedef struct {
    bit            w;
    bit [2:0]      sz;
    bit [AW-1:0]   a;
    bit [DW-1:0]   d;
    int            t;
  } cmd_t;

  typedef struct {
    bit [DW-1:0] d;
    bit          e;
    int          t;
  } rsp_t;

  cmd_t sendq[$];
  cmd_t bq[$];
  rsp_t rq[$];
  logic [DW-1:0] smem[int];
  logic [DW-1:0] rmem[int];

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   zw = 1'b0;
  int   fixed_waits = 0;
  int   gap = 0;
  bit   dp_on = 1'b0;
  cmd_t dpc;
  int   waits = 0;
  bit   err_first = 1'b0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_init(bit [AW-1:0] a);
    return {1'b0, a[AW-1:2], 2'b00} + 32'd1;
  endfunction

  function automatic bit is_err(bit [AW-1:0] a);
    return (a == 31'h7FFF_FFFC) || (a[6:4] == 3'b111);
  endfunction

  function automatic logic [DW-1:0] slave_rd(bit [AW-1:0] a);
    int i = int'(a[AW-1:2]);
    return smem.exists(i) ? smem[i] : mem_init(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(bit [AW-1:0] a);
    int i = int'(a[AW-1:2]);
    return rmem.exists(i) ? rmem[i] : mem_init(a);
  endfunction

  task automatic push_cmd(bit w, bit [2:0] sz, bit [AW-1:0] a,
                          bit [DW-1:0] d);
    cmd_t c;
    c.w = w; c.sz = sz; c.a = a; c.d = d; c.t = 0;
    sendq.push_back(c);
  endtask

  task automatic step();
    rsp_t r;
    cmd_t c;
    bit   done;
    bit   ap_done;
    @(posedge clock);
    cyc++;
    #1;
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        r = rq.pop_front();
        check("rsp_rdata", rsp_rdata, r.d);
        check("rsp_err", rsp_err, r.e);
        if (zw) check("rsp_latency", cyc - r.t, 3);
      end
    end
    check("htrans", htrans, (bq.size() != 0) ? 2 : 0);
    if (bq.size() != 0) begin
      check("haddr", haddr, bq[0].a);
      check("hwrite", hwrite, bq[0].w);
      check("hsize", hsize, bq[0].sz);
    end
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = $urandom;
    done   = 1'b0;
    if (dp_on) begin
      if (dpc.w) check("hwdata", hwdata, dpc.d);
      if (waits > 0) begin
        hready = 1'b0;
        waits--;
      end else if (is_err(dpc.a) && !err_first) begin
        hready = 1'b0;
        hresp = 1'b1;
        err_first = 1'b1;
      end else begin
        hresp = is_err(dpc.a);
        if (hresp) hrdata = '0;
        else if (!dpc.w) hrdata = slave_rd(dpc.a);
        if (dpc.w && !hresp)
          smem[int'(dpc.a[AW-1:2])] = hwdata;
        done = 1'b1;
      end
    end
    if (sendq.size() != 0 && $urandom_range(99) >= gap) begin
      cmd_valid = 1'b1;
      cmd_write = sendq[0].w;
      cmd_size  = sendq[0].sz;
      cmd_addr  = sendq[0].a;
      cmd_wdata = sendq[0].d;
    end else begin
      cmd_valid = 1'b0;
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
    end
    #1;
    check("cmd_ready", cmd_ready, (bq.size() == 0) || hready);
    ap_done = (bq.size() != 0) && hready;
    if (done) dp_on = 1'b0;
    if (ap_done) begin
      dpc = bq.pop_front();
      dp_on = 1'b1;
      err_first = 1'b0;
      if (fixed_waits >= 0) waits = fixed_waits;
      else waits = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
      if (zw) check("nonseq_latency", cyc - dpc.t, 1);
    end
    if (cmd_valid && cmd_ready) begin
      c = sendq.pop_front();
      c.t = cyc;
      bq.push_back(c);
      r.e = is_err(c.a);
      r.d = (c.w || r.e) ? '0 : ref_rd(c.a);
      r.t = cyc;
      if (c.w && !r.e) rmem[int'(c.a[AW-1:2])] = c.d;
      rq.push_back(r);
    end
  endtask

  task automatic run(int budget);
    int  n = 0;
    bit  busy = 1'b1;
    while (busy && n < budget) begin
      step();
      n++;
      busy = (sendq.size() != 0) || (bq.size() != 0)
          || (rq.size() != 0) || dp_on;
    end
    if (busy) check("drain_timeout", 1, 0);
    step();
    step();
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    cmd_valid = 1'b0;
    hready = 1'b1;
    hresp = 1'b0;
    sendq.delete();
    bq.delete();
    rq.delete();
    dp_on = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #2;
    check("rst_htrans", htrans, 0);
    check("rst_haddr", haddr, 0);
    check("rst_hsize", hsize, 0);
    check("rst_hwrite", hwrite, 0);
    check("rst_hwdata", hwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_hung", hung, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    #1;
    reset = 1'b0;

    zw = 1'b1; fixed_waits = 0; gap = 0;
    push_cmd(1'b1, 3'd2, 31'h100, 32'hCAFE_F00D);
    run(50);
    for (int i = 0; i < 4; i++)
      push_cmd(1'b0, 3'd2, AW'(i * 4), 32'h0);
    run(50);

    zw = 1'b0; fixed_waits = 3;
    push_cmd(1'b1, 3'd2, 31'h200, 32'h1234_5678);
    push_cmd(1'b0, 3'd2, 31'h204, 32'h0);
    run(50);

    fixed_waits = 0;
    push_cmd(1'b0, 3'd2, 31'h7FFF_FFFC, 32'h0);
    push_cmd(1'b0, 3'd2, 31'h40, 32'h0);
    run(50);

    fixed_waits = 5;
    push_cmd(1'b1, 3'd2, 31'h300, 32'hDEAD_BEEF);
    begin
      int n = 0;
      while (!dp_on && n < 20) begin step(); n++; end
      check("reach_data_phase", dp_on, 1);
    end
    step();
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_htrans", htrans, 0);
    check("async_rst_rsp_valid", rsp_valid, 0);
    do_reset();
    fixed_waits = -1;
    repeat (10) step();
    push_cmd(1'b0, 3'd2, 31'h44, 32'h0);
    run(50);

    gap = 30;
    for (int i = 0; i < 300; i++)
      push_cmd($urandom_range(1), 3'($urandom_range(7)),
               AW'($urandom_range(63)) << 2, $urandom);
    run(5000);

`ifdef AHB_LITE_CMD_MASTER_TIMEOUT_EN
    do_reset();
    @(posedge clock);
    #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 31'h10;
    hready = 1'b1;
    #1;
    check("tmo_accept0", cmd_ready, 1);
    @(posedge clock);
    #1;
    cmd_addr = 31'h14;
    #1;
    check("tmo_accept1", cmd_ready, 1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      hready = 1'b0;
      #1;
      check("tmo_rsp_valid", rsp_valid, (k == 9) || (k == 10));
      if (k == 9 || k == 10) begin
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_rdata", rsp_rdata, 0);
      end
      check("tmo_hung", hung, k >= 9);
      check("tmo_cmd_ready", cmd_ready, 0);
      check("tmo_htrans", htrans, (k >= 9) ? 0 : 2);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      hready = 1'b1;
      cmd_valid = 1'b1;
      #1;
      check("hung_cmd_ready", cmd_ready, 0);
      check("hung_rsp_valid", rsp_valid, 0);
    end
    do_reset();
    #1;
    check("hung_cleared", hung, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
